// File: rtl/life_pkg.sv
// Shared definitions for the Game of Life generation engine: grid geometry,
// derived index widths, the FSM state type and the B3/S23 rule.
package life_pkg;

  localparam int COLS  = 20;
  localparam int ROWS  = 15;
  localparam int N     = COLS * ROWS;
  localparam int IDX_W = $clog2(N);
  localparam int POP_W = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SWAP = 2'd2
  } state_t;

  // B3/S23: a cell is born with exactly three neighbours and survives with two or three.
  function automatic logic next_state(input logic alive, input logic [3:0] sum);
    return (sum == 4'd3) | (alive & (sum == 4'd2));
  endfunction

endpackage

// File: rtl/life_neighbours.sv
// Combinational neighbour counter for one cell of the toroidal grid.
// The caller supplies the linear index together with its row/column, which it
// tracks with counters, so wrap-around needs only compares and add/subtract.
module life_neighbours #(
  parameter int COLS = life_pkg::COLS,
  parameter int ROWS = life_pkg::ROWS,
  localparam int N     = COLS * ROWS,
  localparam int IDX_W = $clog2(N),
  localparam int ROW_W = $clog2(ROWS),
  localparam int COL_W = $clog2(COLS)
) (
  input  logic [IDX_W-1:0] idx,
  input  logic [ROW_W-1:0] row,
  input  logic [COL_W-1:0] col,
  input  logic [N-1:0]     front,
  output logic [3:0]       sum,
  output logic             centre
);
  import life_pkg::*;

  localparam logic [IDX_W-1:0] STRIDE    = IDX_W'(COLS);
  localparam logic [IDX_W-1:0] ROW_WRAP  = IDX_W'((ROWS - 1) * COLS);
  localparam logic [IDX_W-1:0] COL_WRAP  = IDX_W'(COLS - 1);
  localparam logic [IDX_W-1:0] ONE       = IDX_W'(1);
  localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(COLS - 1);

  logic [IDX_W-1:0] up_base;
  logic [IDX_W-1:0] dn_base;
  logic [IDX_W-1:0] nb [8];

  // Column neighbours of a row base index, wrapping column 0 <-> COLS-1.
  function automatic logic [IDX_W-1:0] left_of(input logic [IDX_W-1:0] b,
                                               input logic [COL_W-1:0] c);
    return (c == '0) ? b + COL_WRAP : b - ONE;
  endfunction

  function automatic logic [IDX_W-1:0] right_of(input logic [IDX_W-1:0] b,
                                                input logic [COL_W-1:0] c);
    return (c == LAST_COL) ? b - COL_WRAP : b + ONE;
  endfunction

  // Locate the eight neighbours (row wrap first, then column wrap) and add them up.
  always_comb begin
    up_base = (row == '0)      ? idx + ROW_WRAP : idx - STRIDE;
    dn_base = (row == LAST_ROW) ? idx - ROW_WRAP : idx + STRIDE;

    nb[0] = left_of(up_base, col);
    nb[1] = up_base;
    nb[2] = right_of(up_base, col);
    nb[3] = left_of(idx, col);
    nb[4] = right_of(idx, col);
    nb[5] = left_of(dn_base, col);
    nb[6] = dn_base;
    nb[7] = right_of(dn_base, col);

    sum = 4'd0;
    for (int k = 0; k < 8; k++) begin
      sum = sum + {3'b000, front[nb[k]]};
    end
    centre = front[idx];
  end

endmodule

// File: rtl/life_engine.sv
// Game of Life generation engine. The front buffer is what the renderer sees;
// a step sweeps every cell once (one per clock) into the back buffer and then
// copies it to the front on a single edge, so a half-built generation is never
// visible. Pattern loads go straight to the front buffer while idle.
module life_engine #(
  parameter int COLS = life_pkg::COLS,
  parameter int ROWS = life_pkg::ROWS,
  localparam int N     = COLS * ROWS,
  localparam int IDX_W = $clog2(N),
  localparam int POP_W = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  output logic             busy,
  output logic             done,
  output logic [15:0]      gen_count,
  output logic [POP_W-1:0] population,
  input  logic [IDX_W-1:0] rd_addr,
  output logic             rd_cell,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic             wr_data
);
  import life_pkg::*;

  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLS);

  localparam logic [IDX_W-1:0] N_IDX    = IDX_W'(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

  state_t           state;
  state_t           state_nxt;

  logic [N-1:0]     front;
  logic [N-1:0]     back;
  logic [IDX_W-1:0] idx;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic [POP_W-1:0] pop_acc;

  logic [3:0]       nb_sum;
  logic             nb_centre;
  logic             cell_next;

  life_neighbours #(
    .COLS(COLS),
    .ROWS(ROWS)
  ) u_neighbours (
    .idx   (idx),
    .row   (row),
    .col   (col),
    .front (front),
    .sum   (nb_sum),
    .centre(nb_centre)
  );

  assign cell_next = next_state(nb_centre, nb_sum);

  // The renderer reads the front buffer with no latency; indices past the grid read as dead.
  assign rd_cell = (rd_addr < N_IDX) ? front[rd_addr] : 1'b0;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: a step starts a sweep, the last cell ends it, the swap takes one edge.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (step) state_nxt = RUN;
      RUN:     if (idx == LAST_IDX) state_nxt = SWAP;
      SWAP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: anything other than idle counts as a generation in flight.
  always_comb begin
    busy = (state != IDLE);
  end

  // Sweep datapath: walk idx with matching row/col counters, writing the back buffer and tallying live cells.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      row     <= '0;
      col     <= '0;
      pop_acc <= '0;
      back    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (step) begin
            idx     <= '0;
            row     <= '0;
            col     <= '0;
            pop_acc <= '0;
          end
        end
        RUN: begin
          back[idx] <= cell_next;
          pop_acc   <= pop_acc + POP_W'(cell_next);
          idx       <= idx + IDX_W'(1);
          if (col == LAST_COL) begin
            col <= '0;
            row <= (row == LAST_ROW) ? '0 : row + ROW_W'(1);
          end else begin
            col <= col + COL_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Front buffer: pattern writes land only while idle; the swap replaces the whole grid at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      front <= '0;
    end else if (state == SWAP) begin
      front <= back;
    end else if (state == IDLE && wr_en && wr_addr < N_IDX) begin
      front[wr_addr] <= wr_data;
    end
  end

  // Generation statistics and the done strobe, all published on the swap edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gen_count  <= '0;
      population <= '0;
      done       <= 1'b0;
    end else begin
      done <= (state == SWAP);
      if (state == SWAP) begin
        gen_count  <= gen_count + 16'd1;
        population <= pop_acc;
      end
    end
  end

endmodule
